// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480 VGA timing constants, pixel record and lock-state enum
package vga_pkg;

  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_ACT   = 640;
  localparam int H_TOTAL = 800;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_ACT   = 480;
  localparam int V_TOTAL = 525;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } pixel_t;

  typedef enum logic [1:0] {
    HUNT,
    CHECK1,
    CHECK2,
    LOCKED
  } lock_state_t;

endpackage

// File: rtl/vga_rx_if.sv
// rtl/vga_rx_if.sv - VGA sync/colour inputs and recovered pixel stream
interface vga_rx_if;

  logic        hsync;
  logic        vsync;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [23:0] pix_data;
  logic        frame_start;
  logic        locked;
  logic        err;

  modport master (
    output hsync, vsync, vga_r, vga_g, vga_b,
    input  pix_valid, pix_x, pix_y, pix_data, frame_start, locked, err
  );

  modport slave (
    input  hsync, vsync, vga_r, vga_g, vga_b,
    output pix_valid, pix_x, pix_y, pix_data, frame_start, locked, err
  );

endinterface

// File: rtl/vga_edge_det.sv
// rtl/vga_edge_det.sv - two-stage sync sampler with rising-edge detect
module vga_edge_det (
  input  logic pclk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic s1;
  logic s2;

  // Syncs idle high, so resetting to 1 avoids a false edge right after reset.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;

endmodule

// File: rtl/vga_rx.sv
// rtl/vga_rx.sv - VGA receiver: coordinate recovery and pixel stream; VGA_RX_CHECK_EN adds timing checks and lock FSM
module vga_rx
  import vga_pkg::*;
#(
  parameter int HBP  = H_BP,
  parameter int HACT = H_ACT,
  parameter int HTOT = H_TOTAL,
  parameter int VBP  = V_BP,
  parameter int VACT = V_ACT,
  parameter int VTOT = V_TOTAL
) (
  input logic     pclk,
  input logic     reset_n,
  vga_rx_if.slave vga
);

  localparam logic [9:0] H_FIRST = 10'(HBP);
  localparam logic [9:0] H_END   = 10'(HBP + HACT);
  localparam logic [9:0] V_FIRST = 10'(VBP);
  localparam logic [9:0] V_END   = 10'(VBP + VACT);

  logic        hs_rise;
  logic        vs_rise;
  logic [23:0] rgb_s1;
  logic [23:0] rgb_s2;
  logic [9:0]  h_cnt;
  logic [9:0]  l_cnt;
  logic        pending;
  logic        synced;
  logic        lock_ok;
  logic        in_win;
  logic        win_ok;
  pixel_t      pix_q;
  logic        pix_valid_q;
  logic        frame_start_q;

  vga_edge_det u_hs (.pclk, .reset_n, .d(vga.hsync), .rise(hs_rise));
  vga_edge_det u_vs (.pclk, .reset_n, .d(vga.vsync), .rise(vs_rise));

  assign in_win = (h_cnt >= H_FIRST) && (h_cnt < H_END) &&
                  (l_cnt >= V_FIRST) && (l_cnt < V_END);
  // l_cnt only means anything once a vsync has anchored it.
  assign win_ok = in_win && synced && lock_ok;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_s1        <= '0;
      rgb_s2        <= '0;
      h_cnt         <= '0;
      l_cnt         <= '0;
      pending       <= 1'b0;
      synced        <= 1'b0;
      pix_q         <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      rgb_s1 <= {vga.vga_r, vga.vga_g, vga.vga_b};
      rgb_s2 <= rgb_s1;
      if (hs_rise) begin
        h_cnt <= '0;
      end else if (h_cnt != 10'h3FF) begin
        h_cnt <= h_cnt + 10'd1;
      end
      if (hs_rise) begin
        if (pending || vs_rise) begin
          l_cnt  <= '0;
          synced <= 1'b1;
        end else if (l_cnt != 10'h3FF) begin
          l_cnt <= l_cnt + 10'd1;
        end
        pending <= 1'b0;
      end else if (vs_rise) begin
        pending <= 1'b1;
      end
      pix_valid_q   <= win_ok;
      frame_start_q <= win_ok && (h_cnt == H_FIRST) && (l_cnt == V_FIRST);
      pix_q.x       <= h_cnt - H_FIRST;
      pix_q.y       <= l_cnt - V_FIRST;
      pix_q.rgb     <= rgb_s2;
    end
  end

`ifdef VGA_RX_CHECK_EN
  localparam logic [9:0] H_LAST = 10'(HTOT - 1);
  localparam logic [9:0] V_LAST = 10'(VTOT - 1);

  lock_state_t state;
  logic        h_seen;
  logic        line_err_seen;
  logic        err_q;
  logic        line_bad;
  logic        frame_bad;

  assign line_bad  = hs_rise && h_seen && (h_cnt != H_LAST);
  assign frame_bad = vs_rise && (l_cnt != V_LAST);

  // A frame that only carried line errors is retried silently; err marks length mismatches.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= HUNT;
      h_seen        <= 1'b0;
      line_err_seen <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (hs_rise) h_seen <= 1'b1;
      if (vs_rise) begin
        line_err_seen <= 1'b0;
      end else if (line_bad) begin
        line_err_seen <= 1'b1;
      end
      if (state == HUNT) begin
        if (vs_rise) state <= CHECK1;
      end else if (line_bad || frame_bad) begin
        state <= CHECK1;
        err_q <= 1'b1;
      end else if (vs_rise) begin
        if (line_err_seen) begin
          state <= CHECK1;
        end else if (state == CHECK1) begin
          state <= CHECK2;
        end else begin
          state <= LOCKED;
        end
      end
    end
  end

  assign lock_ok    = (state == LOCKED);
  assign vga.locked = lock_ok;
  assign vga.err    = err_q;
`else
  assign lock_ok    = 1'b1;
  assign vga.locked = 1'b1;
  assign vga.err    = 1'b0;
`endif

  assign vga.pix_valid   = pix_valid_q;
  assign vga.pix_x       = pix_q.x;
  assign vga.pix_y       = pix_q.y;
  assign vga.pix_data    = pix_q.rgb;
  assign vga.frame_start = frame_start_q;

endmodule

// File: doc/vga_rx.md
# vga_rx

Receiving end of the VGA link: samples hsync/vsync/RGB in the pclk domain, recovers pixel coordinates from sync edges, and emits a pixel write stream (x, y, RGB, valid) for a frame-buffer writer or checker. It also measures line and frame lengths against the 640x480 timing and reports lock and timing errors. It sits after any VGA source in the same clock domain, most commonly the team's own timing generator in loopback.

## Interface
- H_SYNC, 96, hsync low-pulse width (pclk cycles)
- H_BP, 48, cycles from hsync rise to first active pixel
- H_ACT, 640, active pixels per line
- H_TOTAL, 800, pclk cycles per line
- V_SYNC, 2, vsync low-pulse width (lines)
- V_BP, 33, lines from vsync rise to first active line
- V_ACT, 480, active lines per frame
- V_TOTAL, 525, lines per frame
- pclk  in  1  pixel clock, 25 MHz
- reset_n  in  1  asynchronous active-low reset
- hsync  in  1  line sync, active-low pulse
- vsync  in  1  frame sync, active-low pulse
- vga_r / vga_g / vga_b  in  8 each  pixel colour
- pix_valid  out  1  pix_x/pix_y/pix_data carry an active pixel
- pix_x  out  10  column 0..H_ACT-1
- pix_y  out  10  row 0..V_ACT-1
- pix_data  out  24  {r,g,b}
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0)
- locked  out  1  timing verified, stream trustworthy
- err  out  1  one-cycle pulse on any line/frame length mismatch

## Operation
- All inputs registered once (s1), then s1 delayed once more (s2); hsync rise = s1 & ~s2, same for vsync.
- h_cnt (10 b): 0 on hsync rise, else +1, saturates at 1023.
- Line index l_cnt (10 b): on vsync rise set pending flag; on hsync rise, l_cnt <= pending ? 0 : l_cnt+1 (saturate 1023), clear flag. Vsync rise and hsync rise in same cycle: that hsync rise yields l_cnt = 0.
- Active window: H_BP <= h_cnt < H_BP+H_ACT and V_BP <= l_cnt < V_BP+V_ACT; pix_x = h_cnt-H_BP, pix_y = l_cnt-V_BP (10-bit subtract, only meaningful inside window).
- Line check: at each hsync rise (except first after reset) h_cnt must equal H_TOTAL-1.
- Frame check: at each vsync rise (except first after reset) l_cnt must equal V_TOTAL-1 and no line error occurred since previous vsync rise.
- Lock FSM: HUNT -> (first vsync rise) -> CHECK1 -> (good frame) -> CHECK2 -> (good frame) -> LOCKED. Any bad line or frame in CHECK1/CHECK2/LOCKED -> CHECK1 with err pulse. locked = (state == LOCKED).
- pix_valid = window & locked; frame_start = pix_valid & pix_x==0 & pix_y==0.
- Sync loss (no hsync rise): h_cnt saturates, window never true, no err until the next edge arrives and is measured.

## Timing
- Reset: all outputs 0, FSM HUNT, counters 0, pending flag 0.
- Reset asserted mid-frame: immediate return to reset state; relock takes the rest of the partial frame plus two full frames.
- Latency: RGB sampled on pclk edge n appears on pix_data at edge n+2, with pix_x/pix_y equal to the source's coordinate of that pixel (source pixel h_addr 0 -> pix_x 0).
- All outputs registered; err and frame_start are exactly one cycle wide.
- err fires the cycle after the offending edge is detected.

## Configuration
- VGA_RX_CHECK_EN defined: line/frame checks and lock FSM as above.
- Undefined: no checker logic; locked tied 1, err tied 0, pix_valid = window only (valid from the first frame following the first vsync rise).

## Structure
- vga_pkg: the eight timing constants (shared with the generator), pixel typedef {x[9:0], y[9:0], rgb[23:0]}, lock-state enum.
- Sub-module vga_edge_det: input register, delay register, rise-detect; instantiated for hsync and vsync.

## Test plan
- Loopback from the team generator, ramp colour = {x[7:0], y[7:0], 8'h5A}: locked rises at the 3rd vsync rise; then every frame gives 307200 pix_valid cycles with pix_data matching coordinates, exactly one frame_start per frame.
- After lock, stretch one line to 801 cycles: err pulses once, locked drops, returns after two clean frames.
- After lock, frame of 524 lines: err at that vsync rise, locked low, relock after two good frames.
- vsync rise forced into same cycle as hsync rise: that line becomes l_cnt 0; first active row remains at source y 0.
- reset_n low for 3 cycles mid-active line: all outputs 0 within the reset, no pix_valid until relock.
- Build without VGA_RX_CHECK_EN: locked stays 1, err never asserts, pixels valid from the first full frame.
